// File: rtl/chdr_framer_32.sv
// rtl/chdr_framer_32.sv - packs a 32-bit sample stream into buffered 64-bit CHDR data packets
module chdr_framer_32 #(
    parameter int BUF_AWIDTH = 8,
    parameter int HDR_AWIDTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_tx_seqnum,
    input  logic [15:0] src_sid,
    input  logic [15:0] next_dst,
    input  logic [15:0] spp,
    input  logic [31:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [63:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready
);

    localparam int BUF_DEPTH = 1 << BUF_AWIDTH;
    localparam int HDR_DEPTH = 1 << HDR_AWIDTH;
    // Largest packet the payload buffer can hold, in samples.
    localparam logic [15:0]         MAX_SPP      = 16'(2 * BUF_DEPTH);
    localparam logic [BUF_AWIDTH:0] BUF_FULL_CNT = (BUF_AWIDTH + 1)'(BUF_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_PAYLOAD
    } state_t;

    // Payload buffer and its bookkeeping.
    logic [63:0]           buf_mem [BUF_DEPTH];
    logic [BUF_AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [BUF_AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [BUF_AWIDTH:0]   used_q, used_d;

    // Packing state for the packet being assembled.
    logic [31:0] half_q, half_d;
    logic        have_half_q, have_half_d;
    logic [15:0] cnt_q, cnt_d;

    // Closed-packet descriptors: {eob, nsamps[15:0], src_sid, next_dst}.
    logic [48:0]         desc_mem [HDR_DEPTH];
    logic [HDR_AWIDTH:0] dwr_ptr_q, dwr_ptr_d;
    logic [HDR_AWIDTH:0] drd_ptr_q, drd_ptr_d;

    // Output side.
    state_t      state_q, state_d;
    logic [63:0] hdr_q, hdr_d;
    logic [15:0] pay_left_q, pay_left_d;
    logic [11:0] seq_q, seq_d;

    logic [15:0] spp_eff;
    logic [15:0] cnt_inc;
    logic        close_pkt;
    logic        in_hs;
    logic        buf_wr;
    logic        buf_rd;
    logic [63:0] buf_wdata;
    logic        buf_full;
    logic        desc_wr;
    logic [48:0] desc_wdata;
    logic [48:0] desc_head;
    logic        desc_empty;
    logic        desc_full;
    logic        hdr_hs;
    logic        pay_hs;
    logic        pay_last;

    assign spp_eff   = (spp == 16'd0 || spp > MAX_SPP) ? MAX_SPP : spp;
    assign cnt_inc   = cnt_q + 16'd1;
    assign close_pkt = i_tlast || (cnt_inc >= spp_eff);

    assign buf_full   = (used_q == BUF_FULL_CNT);
    assign desc_empty = (dwr_ptr_q == drd_ptr_q);
    assign desc_full  = (dwr_ptr_q[HDR_AWIDTH] != drd_ptr_q[HDR_AWIDTH]) &&
                        (dwr_ptr_q[HDR_AWIDTH-1:0] == drd_ptr_q[HDR_AWIDTH-1:0]);

    // The free count is registered, so a read in the same cycle does not
    // make room for a write until the following cycle.
    assign i_tready = !reset && !buf_full && !desc_full;

    assign in_hs      = i_tvalid && i_tready;
    assign buf_wr     = in_hs && (have_half_q || close_pkt);
    assign buf_wdata  = have_half_q ? {half_q, i_tdata} : {i_tdata, 32'h0};
    assign desc_wr    = in_hs && close_pkt;
    assign desc_wdata = {i_tlast, cnt_inc, src_sid, next_dst};
    assign desc_head  = desc_mem[drd_ptr_q[HDR_AWIDTH-1:0]];

    assign hdr_hs   = (state_q == S_HDR) && o_tready;
    assign pay_hs   = (state_q == S_PAYLOAD) && o_tready;
    assign pay_last = (pay_left_q == 16'd1);
    assign buf_rd   = pay_hs;

    // Input packing: hold the first sample of a pair, write on the second or on close.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        half_d      = half_q;
        have_half_d = have_half_q;
        cnt_d       = cnt_q;
        dwr_ptr_d   = dwr_ptr_q;
        if (in_hs) begin
            if (buf_wr) begin
                wr_ptr_d    = wr_ptr_q + 1'b1;
                have_half_d = 1'b0;
            end else begin
                half_d      = i_tdata;
                have_half_d = 1'b1;
            end
            cnt_d = close_pkt ? 16'd0 : cnt_inc;
        end
        if (desc_wr) begin
            dwr_ptr_d = dwr_ptr_q + 1'b1;
        end
    end

    // Buffer occupancy tracks writes and reads that may land in the same cycle.
    always_comb begin
        used_d = used_q;
        case ({buf_wr, buf_rd})
            2'b10:   used_d = used_q + 1'b1;
            2'b01:   used_d = used_q - 1'b1;
            default: used_d = used_q;
        endcase
    end

    // Header is frozen when leaving IDLE so a later seqnum clear cannot disturb it.
    always_comb begin
        hdr_d      = hdr_q;
        pay_left_d = pay_left_q;
        seq_d      = seq_q;
        rd_ptr_d   = rd_ptr_q;
        drd_ptr_d  = drd_ptr_q;
        if (state_q == S_IDLE && !desc_empty) begin
            hdr_d      = {2'b00, 1'b0, desc_head[48], seq_q,
                          16'd8 + {desc_head[45:32], 2'b00}, desc_head[31:0]};
            pay_left_d = (desc_head[47:32] + 16'd1) >> 1;
            seq_d      = seq_q + 12'd1;
        end
        if (hdr_hs) begin
            drd_ptr_d = drd_ptr_q + 1'b1;
        end
        if (pay_hs) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            pay_left_d = pay_left_q - 16'd1;
        end
        if (clear_tx_seqnum) begin
            seq_d = 12'd0;
        end
    end

    // Payload and descriptor storage; entries are only meaningful behind the pointers.
    always_ff @(posedge clk) begin
        if (buf_wr) begin
            buf_mem[wr_ptr_q] <= buf_wdata;
        end
        if (desc_wr) begin
            desc_mem[dwr_ptr_q[HDR_AWIDTH-1:0]] <= desc_wdata;
        end
    end

    // Pointer, counter and header registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            used_q      <= '0;
            half_q      <= '0;
            have_half_q <= 1'b0;
            cnt_q       <= '0;
            dwr_ptr_q   <= '0;
            drd_ptr_q   <= '0;
            hdr_q       <= '0;
            pay_left_q  <= '0;
            seq_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            used_q      <= used_d;
            half_q      <= half_d;
            have_half_q <= have_half_d;
            cnt_q       <= cnt_d;
            dwr_ptr_q   <= dwr_ptr_d;
            drd_ptr_q   <= drd_ptr_d;
            hdr_q       <= hdr_d;
            pay_left_q  <= pay_left_d;
            seq_q       <= seq_d;
        end
    end

    // Output FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output FSM next state: a header only starts once a packet is fully buffered.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (!desc_empty) state_d = S_HDR;
            S_HDR:     if (o_tready) state_d = S_PAYLOAD;
            S_PAYLOAD: if (o_tready && pay_last) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output FSM outputs; everything here is a function of registers, so it holds during stalls.
    always_comb begin
        o_tvalid = 1'b0;
        o_tlast  = 1'b0;
        o_tdata  = 64'h0;
        if (!reset) begin
            case (state_q)
                S_HDR: begin
                    o_tvalid = 1'b1;
                    o_tdata  = hdr_q;
                end
                S_PAYLOAD: begin
                    o_tvalid = 1'b1;
                    o_tlast  = pay_last;
                    o_tdata  = buf_mem[rd_ptr_q];
                end
                default: begin
                    o_tvalid = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chdr_framer_32.sv
// tb/tb_chdr_framer_32.sv - directed self-checking bench for chdr_framer_32
module tb_chdr_framer_32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear_tx_seqnum = 1'b0;
    logic [15:0] src_sid = 16'h0010;
    logic [15:0] next_dst = 16'h0020;
    logic [15:0] spp = 16'd0;
    logic [31:0] i_tdata = 32'h0;
    logic        i_tlast = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic [63:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready = 1'b1;

    int n_pass = 0;
    int n_total = 0;
    logic [64:0] out_q[$];

    chdr_framer_32 #(.BUF_AWIDTH(8), .HDR_AWIDTH(2)) dut (
        .clk(clk),
        .reset(reset),
        .clear_tx_seqnum(clear_tx_seqnum),
        .src_sid(src_sid),
        .next_dst(next_dst),
        .spp(spp),
        .i_tdata(i_tdata),
        .i_tlast(i_tlast),
        .i_tvalid(i_tvalid),
        .i_tready(i_tready),
        .o_tdata(o_tdata),
        .o_tlast(o_tlast),
        .o_tvalid(o_tvalid),
        .o_tready(o_tready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && o_tvalid && o_tready) out_q.push_back({o_tlast, o_tdata});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_tvalid = 1'b0;
        i_tlast = 1'b0;
        clear_tx_seqnum = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        step();
        out_q.delete();
    endtask

    task automatic push(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        i_tdata = d;
        i_tlast = l;
        i_tvalid = 1'b1;
        while (!i_tready && n < 5000) begin
            step();
            n++;
        end
        if (n >= 5000) begin
            n_total++;
            $display("FAIL push_timeout: i_tready stuck at %b, required 1", i_tready);
        end else begin
            step();
        end
        i_tvalid = 1'b0;
        i_tlast = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int k;
        k = 0;
        while (out_q.size() < n && k < 20000) begin
            step();
            k++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) step();
        n_total++;
        if ({i_tready, o_tvalid, o_tlast} !== 3'b000 || o_tdata !== 64'h0) begin
            $display("FAIL reset_outputs: got rdy=%b vld=%b last=%b data=%h, required 0 0 0 0",
                     i_tready, o_tvalid, o_tlast, o_tdata);
        end else n_pass++;
        reset = 1'b0;
        step();
        n_total++;
        if (i_tready !== 1'b1 || o_tvalid !== 1'b0) begin
            $display("FAIL reset_release: got rdy=%b vld=%b, required 1 0", i_tready, o_tvalid);
        end else n_pass++;
    endtask

    task automatic test_basic();
        logic [64:0] exp [4];
        do_reset();
        spp = 16'd0;
        o_tready = 1'b1;
        exp[0] = {1'b0, 64'h1000_0020_0010_0020};
        exp[1] = {1'b0, 32'hA000_0000, 32'hA000_0001};
        exp[2] = {1'b0, 32'hA000_0002, 32'hA000_0003};
        exp[3] = {1'b1, 32'hA000_0004, 32'hA000_0005};
        for (int i = 0; i < 5; i++) push(32'hA000_0000 + 32'(i), 1'b0);
        push(32'hA000_0005, 1'b1);
        n_total++;
        if (o_tvalid !== 1'b0) $display("FAIL basic_lat1: o_tvalid %b, required 0", o_tvalid);
        else n_pass++;
        step();
        n_total++;
        if (o_tvalid !== 1'b1 || o_tdata !== 64'h1000_0020_0010_0020) begin
            $display("FAIL basic_lat2: vld=%b data=%h, required 1 %h", o_tvalid, o_tdata,
                     64'h1000_0020_0010_0020);
        end else n_pass++;
        wait_out(4);
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (out_q.size() <= i) $display("FAIL basic_word%0d: missing, required %h", i, exp[i]);
            else if (out_q[i] !== exp[i])
                $display("FAIL basic_word%0d: got %h, required %h", i, out_q[i], exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_odd();
        logic [64:0] exp [4];
        do_reset();
        exp[0] = {1'b0, 64'h1000_001C_0010_0020};
        exp[1] = {1'b0, 32'hB000_0000, 32'hB000_0001};
        exp[2] = {1'b0, 32'hB000_0002, 32'hB000_0003};
        exp[3] = {1'b1, 32'hB000_0004, 32'h0000_0000};
        for (int i = 0; i < 5; i++) push(32'hB000_0000 + 32'(i), i == 4);
        wait_out(4);
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (out_q.size() <= i) $display("FAIL odd_word%0d: missing, required %h", i, exp[i]);
            else if (out_q[i] !== exp[i])
                $display("FAIL odd_word%0d: got %h, required %h", i, out_q[i], exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_spp();
        logic [64:0] exp [8];
        do_reset();
        spp = 16'd4;
        exp[0] = {1'b0, 64'h0000_0018_0010_0020};
        exp[1] = {1'b0, 32'hC000_0000, 32'hC000_0001};
        exp[2] = {1'b1, 32'hC000_0002, 32'hC000_0003};
        exp[3] = {1'b0, 64'h0001_0018_0010_0020};
        exp[4] = {1'b0, 32'hC000_0004, 32'hC000_0005};
        exp[5] = {1'b1, 32'hC000_0006, 32'hC000_0007};
        exp[6] = {1'b0, 64'h1002_0010_0010_0020};
        exp[7] = {1'b1, 32'hC000_0008, 32'hC000_0009};
        for (int i = 0; i < 10; i++) push(32'hC000_0000 + 32'(i), i == 9);
        wait_out(8);
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (out_q.size() <= i) $display("FAIL spp_word%0d: missing, required %h", i, exp[i]);
            else if (out_q[i] !== exp[i])
                $display("FAIL spp_word%0d: got %h, required %h", i, out_q[i], exp[i]);
            else n_pass++;
        end
        spp = 16'd0;
    endtask

    task automatic test_seq_wrap();
        int errs;
        int k;
        logic [11:0] s;
        logic [64:0] eh;
        logic [64:0] ep;
        do_reset();
        o_tready = 1'b1;
        for (int p = 0; p < 4197; p++) push(32'(p), 1'b1);
        k = 0;
        while (!(o_tvalid && !o_tlast && o_tdata[59:48] == 12'd100) && k < 100) begin
            step();
            k++;
        end
        clear_tx_seqnum = 1'b1;
        step();
        clear_tx_seqnum = 1'b0;
        push(32'd4197, 1'b1);
        wait_out(2 * 4198);
        n_total++;
        if (out_q.size() != 2 * 4198)
            $display("FAIL wrap_count: got %0d words, required %0d", out_q.size(), 2 * 4198);
        else n_pass++;
        errs = 0;
        for (int p = 0; p < 4198 && 2 * p + 1 < out_q.size(); p++) begin
            s = (p == 4197) ? 12'd0 : 12'(p % 4096);
            eh = {1'b0, 4'b0001, s, 16'd12, 32'h0010_0020};
            ep = {1'b1, 32'(p), 32'h0};
            if (out_q[2 * p] !== eh || out_q[2 * p + 1] !== ep) errs++;
        end
        n_total++;
        if (errs != 0) $display("FAIL wrap_stream: got %0d bad packets, required 0", errs);
        else n_pass++;
        n_total++;
        if (out_q[2 * 4095] !== {1'b0, 64'h1FFF_000C_0010_0020})
            $display("FAIL wrap_4095: got %h, required %h", out_q[2 * 4095], {1'b0, 64'h1FFF_000C_0010_0020});
        else n_pass++;
        n_total++;
        if (out_q[2 * 4096] !== {1'b0, 64'h1000_000C_0010_0020})
            $display("FAIL wrap_0: got %h, required %h", out_q[2 * 4096], {1'b0, 64'h1000_000C_0010_0020});
        else n_pass++;
        n_total++;
        if (out_q[2 * 4196] !== {1'b0, 64'h1064_000C_0010_0020})
            $display("FAIL clear_hold: got %h, required %h", out_q[2 * 4196], {1'b0, 64'h1064_000C_0010_0020});
        else n_pass++;
        n_total++;
        if (out_q[2 * 4197] !== {1'b0, 64'h1000_000C_0010_0020})
            $display("FAIL clear_next: got %h, required %h", out_q[2 * 4197], {1'b0, 64'h1000_000C_0010_0020});
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [64:0] exp [10];
        logic        pv, pl, pr;
        logic [63:0] pd;
        int          stab_errs;
        int          stalls;
        int          it;
        do_reset();
        o_tready = 1'b0;
        for (int p = 0; p < 5; p++) begin
            exp[2 * p]     = {1'b0, 4'b0001, 12'(p), 16'd16, 32'h0010_0020};
            exp[2 * p + 1] = {1'b1, 32'hD000_0000 + 32'(16 * p), 32'hD000_0001 + 32'(16 * p)};
        end
        for (int p = 0; p < 4; p++) begin
            push(32'hD000_0000 + 32'(16 * p), 1'b0);
            push(32'hD000_0001 + 32'(16 * p), 1'b1);
        end
        n_total++;
        if (i_tready !== 1'b0) $display("FAIL stall_full: i_tready %b, required 0", i_tready);
        else n_pass++;
        n_total++;
        if (o_tvalid !== 1'b1 || o_tdata !== exp[0][63:0])
            $display("FAIL stall_hdr: vld=%b data=%h, required 1 %h", o_tvalid, o_tdata, exp[0][63:0]);
        else n_pass++;
        repeat (3) step();
        n_total++;
        if (o_tvalid !== 1'b1 || o_tdata !== exp[0][63:0] || i_tready !== 1'b0)
            $display("FAIL stall_hold: vld=%b data=%h rdy=%b, required 1 %h 0", o_tvalid, o_tdata,
                     i_tready, exp[0][63:0]);
        else n_pass++;
        stab_errs = 0;
        stalls = 0;
        it = 0;
        while (out_q.size() < 8 && it < 200) begin
            o_tready = (it % 3) != 0;
            pv = o_tvalid;
            pd = o_tdata;
            pl = o_tlast;
            pr = o_tready;
            step();
            if (pv && !pr) begin
                stalls++;
                if (o_tvalid !== 1'b1 || o_tdata !== pd || o_tlast !== pl) stab_errs++;
            end
            it++;
        end
        n_total++;
        if (stab_errs != 0 || stalls == 0)
            $display("FAIL stall_stable: got %0d unstable of %0d stalls, required 0 of >0", stab_errs, stalls);
        else n_pass++;
        o_tready = 1'b1;
        push(32'hD000_0040, 1'b0);
        push(32'hD000_0041, 1'b1);
        wait_out(10);
        for (int i = 0; i < 10; i++) begin
            n_total++;
            if (out_q.size() <= i) $display("FAIL stall_word%0d: missing, required %h", i, exp[i]);
            else if (out_q[i] !== exp[i])
                $display("FAIL stall_word%0d: got %h, required %h", i, out_q[i], exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [64:0] exp [2];
        do_reset();
        o_tready = 1'b1;
        exp[0] = {1'b0, 64'h1000_0010_0010_0020};
        exp[1] = {1'b1, 32'hE000_0010, 32'hE000_0011};
        for (int i = 0; i < 3; i++) push(32'hE000_0000 + 32'(i), 1'b0);
        reset = 1'b1;
        step();
        n_total++;
        if (o_tvalid !== 1'b0 || i_tready !== 1'b0)
            $display("FAIL midrst_out: vld=%b rdy=%b, required 0 0", o_tvalid, i_tready);
        else n_pass++;
        reset = 1'b0;
        step();
        push(32'hE000_0010, 1'b0);
        push(32'hE000_0011, 1'b1);
        wait_out(2);
        repeat (4) step();
        n_total++;
        if (out_q.size() != 2) $display("FAIL midrst_count: got %0d words, required 2", out_q.size());
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            n_total++;
            if (out_q.size() <= i) $display("FAIL midrst_word%0d: missing, required %h", i, exp[i]);
            else if (out_q[i] !== exp[i])
                $display("FAIL midrst_word%0d: got %h, required %h", i, out_q[i], exp[i]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_odd();
        test_spp();
        test_seq_wrap();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
